// File: rtl/instr_exec_sequencer.sv
// Walks a start..end slot range of the instruction register and writes each slot's 64-bit result back.
// Optional INSTR_SEQ_STATS_EN adds per-run write-back and divide-by-zero counters.
package instr_exec_pkg;
  typedef logic [4:0]         address_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    logic [3:0]         opcode;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
  } instruction_t;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;
endpackage

module instr_exec_sequencer
  import instr_exec_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_addr,
  input  address_t     end_addr,
  output logic         busy,
  output logic         done,
  output address_t     read_pointer,
  input  instruction_t instr_word,
  output logic         wb_en,
  output address_t     wb_addr,
  output result_t      wb_result,
  output logic         div0_err
`ifdef INSTR_SEQ_STATS_EN
  ,
  output logic [5:0]   exec_count,
  output logic [5:0]   div0_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state;
  logic [1:0]   fetch_cnt;
  address_t     end_q;
  instruction_t instr_q;

  result_t a64, b64, exec_result;
  logic    exec_div0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a64         = {{32{instr_q.op_a[31]}}, instr_q.op_a};
    b64         = {{32{instr_q.op_b[31]}}, instr_q.op_b};
    exec_result = '0;
    exec_div0   = 1'b0;
    case (instr_q.opcode)
      OP_ZERO:  exec_result = '0;
      OP_PASSA: exec_result = a64;
      OP_PASSB: exec_result = b64;
      OP_ADD:   exec_result = a64 + b64;
      OP_SUB:   exec_result = a64 - b64;
      OP_MULT:  exec_result = a64 * b64;
      // 64-bit division keeps -2^31 / -1 representable as +2^31.
      OP_DIV: begin
        if (b64 == '0) exec_div0 = 1'b1;
        else           exec_result = a64 / b64;
      end
      OP_MOD: begin
        if (b64 == '0) exec_div0 = 1'b1;
        else           exec_result = a64 % b64;
      end
      default:  exec_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      fetch_cnt    <= '0;
      end_q        <= '0;
      instr_q      <= '0;
      read_pointer <= '0;
      wb_addr      <= '0;
      wb_result    <= '0;
      div0_err     <= 1'b0;
`ifdef INSTR_SEQ_STATS_EN
      exec_count   <= '0;
      div0_count   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            end_q        <= end_addr;
            read_pointer <= start_addr;
            div0_err     <= 1'b0;
            fetch_cnt    <= '0;
            state        <= S_FETCH;
`ifdef INSTR_SEQ_STATS_EN
            exec_count   <= '0;
            div0_count   <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (fetch_cnt == 2'(RD_LATENCY)) begin
            instr_q <= instr_word;
            state   <= S_EXEC;
          end else begin
            fetch_cnt <= fetch_cnt + 2'd1;
          end
        end
        S_EXEC: begin
          wb_result <= exec_result;
          wb_addr   <= read_pointer;
          if (exec_div0) begin
            div0_err   <= 1'b1;
`ifdef INSTR_SEQ_STATS_EN
            div0_count <= div0_count + 6'd1;
`endif
          end
          state <= S_WB;
        end
        S_WB: begin
`ifdef INSTR_SEQ_STATS_EN
          exec_count <= exec_count + 6'd1;
`endif
          if (read_pointer == end_q) begin
            state <= S_DONE;
          end else begin
            read_pointer <= read_pointer + 5'd1;
            fetch_cnt    <= '0;
            state        <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status strobes decode straight from the state register, so reset clears them at once.
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wb_en = (state == S_WB);

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Self-checking bench for instr_exec_sequencer: a spec-level model fills a write-back queue
// that a per-cycle compare process drains; directed runs pin timing, flags and reset behaviour.
module tb_instr_exec_sequencer;
  import instr_exec_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  address_t     start_addr, end_addr;
  logic         busy, done, wb_en, div0_err;
  address_t     read_pointer, wb_addr;
  result_t      wb_result;
  instruction_t instr_word;
`ifdef INSTR_SEQ_STATS_EN
  logic [5:0]   exec_count, div0_count;
`endif

  instruction_t mem [32];

  typedef struct {
    logic [4:0] addr;
    longint     res;
  } wb_exp_t;
  wb_exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wb_seen  = 0;

  instr_exec_sequencer #(.RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy), .done(done), .read_pointer(read_pointer),
    .instr_word(instr_word), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_result(wb_result), .div0_err(div0_err)
`ifdef INSTR_SEQ_STATS_EN
    , .exec_count(exec_count), .div0_count(div0_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction register with one cycle of read latency.
  always @(posedge clk) instr_word <= mem[read_pointer];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic instruction_t mk(input logic [3:0] op, input int a, input int b);
    instruction_t t;
    t.opcode = op;
    t.op_a   = a;
    t.op_b   = b;
    return t;
  endfunction

  // Result from the arithmetic rules: truncating quotient, remainder takes the dividend's sign.
  function automatic longint model_result(input instruction_t ins, output bit dz);
    longint a, b, mag, q;
    a  = longint'(ins.op_a);
    b  = longint'(ins.op_b);
    dz = 1'b0;
    model_result = 0;
    if ((ins.opcode == 4'd6 || ins.opcode == 4'd7) && b == 0) begin
      dz = 1'b1;
    end else if (ins.opcode == 4'd6 || ins.opcode == 4'd7) begin
      mag = (a < 0 ? -a : a) / (b < 0 ? -b : b);
      q   = ((a < 0) != (b < 0)) ? -mag : mag;
      model_result = (ins.opcode == 4'd6) ? q : a - q * b;
    end else begin
      case (ins.opcode)
        4'd1:    model_result = a;
        4'd2:    model_result = b;
        4'd3:    model_result = a + b;
        4'd4:    model_result = a - b;
        4'd5:    model_result = a * b;
        default: model_result = 0;
      endcase
    end
  endfunction

  // Per-cycle compare of every write-back against the expected queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_en === 1'b1) begin
      wb_seen++;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", wb_en, 0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check("wb_addr", wb_addr, e.addr);
        check("wb_result", wb_result, e.res);
      end
    end
  end

  // Drives start at the current negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [4:0] s, input logic [4:0] e);
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run(input logic [4:0] s, input logic [4:0] e, input bit push_model);
    int         n, c, dz_cnt;
    bit         dz, busy_ok;
    logic [4:0] a;
    wb_exp_t    x;
    n      = int'(5'(e - s)) + 1;
    dz_cnt = 0;
    for (int i = 0; i < n; i++) begin
      a     = 5'(s + 5'(i));
      x.addr = a;
      x.res  = model_result(mem[a], dz);
      if (dz) dz_cnt++;
      if (push_model) exp_q.push_back(x);
    end
    launch(s, e);
    check("busy_cycle1", busy, 1);
    check("div0_cleared_on_start", div0_err, 0);
    check("rp_start", read_pointer, s);
`ifdef INSTR_SEQ_STATS_EN
    check("exec_count_cleared", exec_count, 0);
    check("div0_count_cleared", div0_count, 0);
`endif
    c       = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_cycle", c, n * 4 + 1);
    check("busy_through_run", busy_ok, 1);
    check("div0_err", div0_err, (dz_cnt > 0) ? 1 : 0);
`ifdef INSTR_SEQ_STATS_EN
    check("exec_count", exec_count, n);
    check("div0_count", div0_count, dz_cnt);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("wb_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_exp_t x;
    for (int i = 0; i < 32; i++) mem[i] = mk(4'(i % 8), i * 1000 - 7, i - 3);
    start = 1'b0; start_addr = '0; end_addr = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_result", wb_result, 0);
    check("rst_div0", div0_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single slot ADD 5 + -7.
    mem[0] = mk(OP_ADD, 5, -7);
    x.addr = 5'd0; x.res = -2; exp_q.push_back(x);
    run(5'd0, 5'd0, 1'b0);

    // Signed corner cases, hand-computed expectations.
    mem[0] = mk(OP_MULT, 32'sh8000_0000, 32'sh8000_0000);
    mem[1] = mk(OP_DIV, -7, 2);
    mem[2] = mk(OP_MOD, -7, 2);
    mem[3] = mk(OP_DIV, 32'sh8000_0000, -1);
    x.addr = 5'd0; x.res = 64'sh4000_0000_0000_0000; exp_q.push_back(x);
    x.addr = 5'd1; x.res = -3;                       exp_q.push_back(x);
    x.addr = 5'd2; x.res = -1;                       exp_q.push_back(x);
    x.addr = 5'd3; x.res = 64'sh0000_0000_8000_0000; exp_q.push_back(x);
    run(5'd0, 5'd3, 1'b0);

    // Divide by zero: flag set, result 0, held in idle.
    mem[4] = mk(OP_DIV, 9, 0);
    run(5'd4, 5'd4, 1'b1);
    repeat (3) @(negedge clk);
    check("div0_held_idle", div0_err, 1);
    check("wb_result_held", wb_result, 0);
    check("wb_addr_held", wb_addr, 4);

    // Wrapping range 30..1.
    run(5'd30, 5'd1, 1'b1);

    // Full 32-slot sweep with three divide-by-zero slots.
    mem[4]  = mk(OP_SUB, 100, 250);
    mem[5]  = mk(OP_DIV, 11, 0);
    mem[17] = mk(OP_MOD, -4, 0);
    mem[29] = mk(OP_DIV, 0, 0);
    run(5'd0, 5'd31, 1'b1);
    run(5'd2, 5'd2, 1'b1);

    // Mid-run reset: extra start ignored, reset during the second EXEC.
    x.addr = 5'd0; x.res = model_result(mem[0], x.addr[0]); exp_q.push_back(x);
    x.addr = 5'd0;
    wb_seen = 0;
    launch(5'd0, 5'd7);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start_addr = 5'd20; end_addr = 5'd25; start = 1'b1;
      end
      if (c == 4) begin
        start = 1'b0;
        check("ignored_start_rp", read_pointer, 0);
        check("wb_en_cycle4", wb_en, 1);
      end
    end
    check("pre_reset_rp", read_pointer, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rp", read_pointer, 0);
    check("midrst_wb_en", wb_en, 0);
    check("midrst_wb_addr", wb_addr, 0);
    check("midrst_wb_result", wb_result, 0);
    check("midrst_div0", div0_err, 0);
`ifdef INSTR_SEQ_STATS_EN
    check("midrst_exec_count", exec_count, 0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("wb_count_reset_run", wb_seen, 1);
    check("busy_after_reset", busy, 0);
    check("queue_after_reset", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
